genius_ctrl: RTL and testbench

//  Round controller for the Genius (Simon) game. Drives the address of the

---
 rtl/genius_pkg.sv | 27 ++
 rtl/genius_timer.sv | 32 +++
 rtl/genius_ctrl.sv | 156 +++++++++++++++
 tb/tb_genius_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/genius_pkg.sv
// Shared types and constants for the Genius (Simon) round controller.
// State encoding, LED patterns and a width helper for the cycle timer.
package genius_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SHOW_ON  = 3'd1,
    S_SHOW_OFF = 3'd2,
    S_WAIT_IN  = 3'd3,
    S_WIN      = 3'd4,
    S_LOSE     = 3'd5
  } state_t;

  localparam logic [3:0] LED_ALL = 4'b1111;
  localparam logic [3:0] LED_OFF = 4'b0000;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/genius_timer.sv
// Saturating up-counter with clear, load and enable; done when it
// reaches the compare limit supplied by the controller.
module genius_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= din;
    end else if (en && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

  assign done = (cnt == limit);

endmodule

// File: rtl/genius_ctrl.sv
// Genius round controller: plays items 0..fase, then checks presses.
// Define TIMEOUT_EN to lose after T_LIMIT idle cycles in WAIT_IN.
module genius_ctrl
  import genius_pkg::*;
#(
  parameter int SIZE    = 4,
  parameter int T_ON    = 50000000,
  parameter int T_OFF   = 12500000,
  parameter int T_LIMIT = 250000000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [3:0]      botoes,
  output logic [SIZE-1:0] seq_addr,
  input  logic [3:0]      seq_data,
  output logic [3:0]      leds,
  output logic [SIZE-1:0] fase,
  output logic            busy,
  output logic            vitoria,
  output logic            derrota
);

  localparam int TW = $clog2(max3(T_ON, T_OFF, T_LIMIT) + 1);
  localparam logic [TW-1:0] LIM_ON   = TW'(T_ON - 1);
  localparam logic [TW-1:0] LIM_OFF  = TW'(T_OFF - 1);
  localparam logic [TW-1:0] LIM_WAIT = TW'(T_LIMIT - 1);
  localparam logic [SIZE-1:0] LAST   = {SIZE{1'b1}};

  state_t          state, state_n;
  logic [SIZE-1:0] idx, idx_n;
  logic [SIZE-1:0] fase_q, fase_n;
  logic            pre, pre_n;
  logic            restart;
  logic            done;
  logic            clr;
  logic [TW-1:0]   limit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      idx    <= '0;
      fase_q <= '0;
      pre    <= 1'b0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      fase_q <= fase_n;
      pre    <= pre_n;
    end
  end

  // pre marks the gap after a completed round: replay restarts at item 0
  always_comb begin
    state_n = state;
    idx_n   = idx;
    fase_n  = fase_q;
    pre_n   = pre;
    restart = 1'b0;
    case (state)
      S_IDLE, S_WIN, S_LOSE: begin
        if (start) begin
          state_n = S_SHOW_ON;
          idx_n   = '0;
          fase_n  = '0;
          pre_n   = 1'b0;
        end
      end
      S_SHOW_ON: begin
        if (done) state_n = S_SHOW_OFF;
      end
      S_SHOW_OFF: begin
        if (done) begin
          if (pre) begin
            pre_n   = 1'b0;
            state_n = S_SHOW_ON;
          end else if (idx < fase_q) begin
            idx_n   = idx + SIZE'(1);
            state_n = S_SHOW_ON;
          end else begin
            idx_n   = '0;
            state_n = S_WAIT_IN;
          end
        end
      end
      S_WAIT_IN: begin
        if (botoes != LED_OFF) begin
          if (botoes == seq_data) begin
            if (idx < fase_q) begin
              idx_n   = idx + SIZE'(1);
              restart = 1'b1;
            end else if (fase_q == LAST) begin
              state_n = S_WIN;
            end else begin
              fase_n  = fase_q + SIZE'(1);
              idx_n   = '0;
              pre_n   = 1'b1;
              state_n = S_SHOW_OFF;
            end
          end else begin
            state_n = S_LOSE;
          end
        end
`ifdef TIMEOUT_EN
        else if (done) begin
          state_n = S_LOSE;
        end
`endif
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    limit = {TW{1'b1}};
    case (state)
      S_SHOW_ON:  limit = LIM_ON;
      S_SHOW_OFF: limit = LIM_OFF;
      S_WAIT_IN:  limit = LIM_WAIT;
      default:    limit = {TW{1'b1}};
    endcase
  end

  assign clr = (state_n != state) || restart;

  genius_timer #(
    .W(TW)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .load (1'b0),
    .din  ({TW{1'b0}}),
    .en   (1'b1),
    .limit(limit),
    .done (done)
  );

  always_comb begin
    leds = LED_OFF;
    case (state)
      S_SHOW_ON: leds = seq_data;
      S_WAIT_IN: leds = botoes;
      S_WIN:     leds = LED_ALL;
      default:   leds = LED_OFF;
    endcase
  end

  assign busy     = (state == S_SHOW_ON) || (state == S_SHOW_OFF)
                 || (state == S_WAIT_IN);
  assign vitoria  = (state == S_WIN);
  assign derrota  = (state == S_LOSE);
  assign seq_addr = idx;
  assign fase     = fase_q;

endmodule

// File: tb/tb_genius_ctrl.sv
// Directed bench for genius_ctrl with short timing (T_ON=4, T_OFF=2).
// Timeout scenario follows TIMEOUT_EN as the design does.
module tb_genius_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] botoes;
  logic [3:0] seq_addr;
  logic [3:0] seq_data;
  logic [3:0] leds;
  logic [3:0] fase;
  logic       busy;
  logic       vitoria;
  logic       derrota;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  genius_ctrl #(
    .SIZE(4), .T_ON(4), .T_OFF(2), .T_LIMIT(20)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .botoes  (botoes),
    .seq_addr(seq_addr),
    .seq_data(seq_data),
    .leds    (leds),
    .fase    (fase),
    .busy    (busy),
    .vitoria (vitoria),
    .derrota (derrota)
  );

  // ROM: 0->0001, 1->0100, 2->0001, 3->1000, 4->0010, ...
  function automatic logic [3:0] rom(input logic [3:0] a);
    int v;
    v = int'(a);
    return 4'b0001 << ((v * 2 + v / 3) % 4);
  endfunction

  assign seq_data = rom(seq_addr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; botoes = 4'b0;
    repeat (3) step();
    n_cmp++; if (leds !== 4'b0) begin n_bad++; $display("FAIL rst_leds got=%b want=0000", leds); end
    n_cmp++; if (seq_addr !== 4'd0) begin n_bad++; $display("FAIL rst_addr got=%0d want=0", seq_addr); end
    n_cmp++; if (fase !== 4'd0) begin n_bad++; $display("FAIL rst_fase got=%0d want=0", fase); end
    n_cmp++; if ({busy, vitoria, derrota} !== 3'b000) begin n_bad++; $display("FAIL rst_flags got=%b want=000", {busy, vitoria, derrota}); end
    rst_n = 1'b1;
    step();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy got=%b want=0", busy); end
  endtask

  task automatic test_start();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (leds !== 4'b0001 || busy !== 1'b1) begin n_bad++; $display("FAIL start_on[%0d] leds=%b busy=%b want 0001/1", k, leds, busy); end
      step();
    end
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (leds !== 4'b0000 || busy !== 1'b1) begin n_bad++; $display("FAIL start_off[%0d] leds=%b busy=%b want 0000/1", k, leds, busy); end
      step();
    end
    n_cmp++; if (busy !== 1'b1 || seq_addr !== 4'd0 || leds !== 4'b0) begin n_bad++; $display("FAIL start_wait busy=%b addr=%0d leds=%b want 1/0/0000", busy, seq_addr, leds); end
  endtask

  task automatic test_round();
    botoes = 4'b0001;
    #1;
    n_cmp++; if (leds !== 4'b0001) begin n_bad++; $display("FAIL echo got=%b want=0001", leds); end
    step();
    botoes = 4'b0;
    n_cmp++; if (fase !== 4'd1) begin n_bad++; $display("FAIL round_fase got=%0d want=1", fase); end
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (leds !== 4'b0) begin n_bad++; $display("FAIL round_gap[%0d] got=%b want=0000", k, leds); end
      step();
    end
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++; if (leds !== rom(4'(i)) || seq_addr !== 4'(i)) begin n_bad++; $display("FAIL replay_on[%0d,%0d] leds=%b addr=%0d want %b/%0d", i, k, leds, seq_addr, rom(4'(i)), i); end
        step();
      end
      for (int k = 0; k < 2; k++) begin
        n_cmp++; if (leds !== 4'b0) begin n_bad++; $display("FAIL replay_off[%0d,%0d] got=%b want=0000", i, k, leds); end
        step();
      end
    end
    n_cmp++; if (busy !== 1'b1 || seq_addr !== 4'd0 || fase !== 4'd1) begin n_bad++; $display("FAIL round_wait busy=%b addr=%0d fase=%0d want 1/0/1", busy, seq_addr, fase); end
  endtask

  task automatic test_lose();
    botoes = 4'b0010;
    step();
    botoes = 4'b0;
    n_cmp++; if (derrota !== 1'b1 || leds !== 4'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL lose_wrong derrota=%b leds=%b busy=%b want 1/0000/0", derrota, leds, busy); end
    start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++; if (fase !== 4'd0 || leds !== 4'b0001 || busy !== 1'b1 || derrota !== 1'b0) begin n_bad++; $display("FAIL lose_restart fase=%0d leds=%b busy=%b derrota=%b want 0/0001/1/0", fase, leds, busy, derrota); end
    repeat (6) step();
    botoes = 4'b0101;
    step();
    botoes = 4'b0;
    n_cmp++; if (derrota !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL lose_multi derrota=%b busy=%b want 1/0", derrota, busy); end
    start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1 || leds !== 4'b0001 || fase !== 4'd0) begin n_bad++; $display("FAIL lose_start busy=%b leds=%b fase=%0d want 1/0001/0", busy, leds, fase); end
  endtask

  task automatic test_timeout();
    repeat (6) step();
`ifdef TIMEOUT_EN
    repeat (19) step();
    n_cmp++; if (derrota !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL to_edge derrota=%b busy=%b want 0/1", derrota, busy); end
    botoes = 4'b0001;
    step();
    botoes = 4'b0;
    n_cmp++; if (fase !== 4'd1 || derrota !== 1'b0) begin n_bad++; $display("FAIL to_lastpress fase=%0d derrota=%b want 1/0", fase, derrota); end
    repeat (14) step();
    repeat (10) step();
    botoes = 4'b0001;
    step();
    botoes = 4'b0;
    repeat (19) step();
    n_cmp++; if (derrota !== 1'b0 || seq_addr !== 4'd1) begin n_bad++; $display("FAIL to_restart derrota=%b addr=%0d want 0/1", derrota, seq_addr); end
    step();
    n_cmp++; if (derrota !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL to_expire derrota=%b busy=%b want 1/0", derrota, busy); end
`else
    repeat (1000) step();
    n_cmp++; if (busy !== 1'b1 || derrota !== 1'b0 || seq_addr !== 4'd0) begin n_bad++; $display("FAIL no_timeout busy=%b derrota=%b addr=%0d want 1/0/0", busy, derrota, seq_addr); end
`endif
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_win();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (6) step();
    for (int f = 0; f < 16; f++) begin
      n_cmp++; if (fase !== 4'(f) || busy !== 1'b1) begin n_bad++; $display("FAIL win_fase got=%0d busy=%b want %0d/1", fase, busy, f); end
      for (int i = 0; i <= f; i++) begin
        n_cmp++; if (seq_addr !== 4'(i)) begin n_bad++; $display("FAIL win_addr[%0d,%0d] got=%0d want=%0d", f, i, seq_addr, i); end
        botoes = rom(4'(i));
        step();
        botoes = 4'b0;
      end
      if (f < 15) repeat (2 + 6 * (f + 2)) step();
    end
    n_cmp++; if (vitoria !== 1'b1 || leds !== 4'b1111 || busy !== 1'b0 || derrota !== 1'b0) begin n_bad++; $display("FAIL win_final vitoria=%b leds=%b busy=%b derrota=%b want 1/1111/0/0", vitoria, leds, busy, derrota); end
    n_cmp++; if (fase !== 4'd15) begin n_bad++; $display("FAIL win_nowrap got=%0d want=15", fase); end
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (6) step();
    botoes = rom(4'd0);
    step();
    botoes = 4'b0;
    repeat (14) step();
    botoes = rom(4'd0);
    step();
    botoes = rom(4'd1);
    step();
    botoes = 4'b0;
    repeat (2) step();
    n_cmp++; if (fase !== 4'd2 || leds !== rom(4'd0)) begin n_bad++; $display("FAIL mid_show fase=%0d leds=%b want 2/%b", fase, leds, rom(4'd0)); end
    botoes = rom(4'd0);
    start = 1'b1;
    step();
    botoes = 4'b0;
    start = 1'b0;
    n_cmp++; if (fase !== 4'd2 || seq_addr !== 4'd0 || leds !== rom(4'd0) || busy !== 1'b1) begin n_bad++; $display("FAIL mid_ignore fase=%0d addr=%0d leds=%b busy=%b want 2/0/%b/1", fase, seq_addr, leds, busy, rom(4'd0)); end
    rst_n = 1'b0;
    step();
    n_cmp++; if ({leds, fase, seq_addr} !== 12'h000 || {busy, vitoria, derrota} !== 3'b000) begin n_bad++; $display("FAIL mid_reset leds=%b fase=%0d addr=%0d flags=%b want all 0", leds, fase, seq_addr, {busy, vitoria, derrota}); end
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    botoes = 4'b0;
    test_reset();
    test_start();
    test_round();
    test_lose();
    test_timeout();
    test_win();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
